// File: rtl/descrambler_pkg.sv
// Shared constants and tap evaluation for the multiplicative descrambler.
package descrambler_pkg;

  localparam int unsigned MAX_W = 64;

  localparam logic [29:0] DEFAULT_POLY = 30'h3000_6000;
  localparam logic [29:0] DEFAULT_SEED = 30'h2AAA_AAAA;

  // out[i] = c[W+i] ^ XOR_k c[W+i-k], with c = {frame, hist}; bits at and above data_w are don't-care.
  function automatic logic [MAX_W-1:0] descramble_taps(
    input logic [MAX_W-1:0] hist,
    input logic [MAX_W-1:0] frame,
    input logic [MAX_W-1:0] poly,
    input int unsigned      data_w
  );
    logic [2*MAX_W-1:0] c;
    logic [MAX_W-1:0]   acc;
    logic [MAX_W-1:0]   p;
    c   = {MAX_W'(0), hist} | ((2*MAX_W)'(frame) << data_w);
    acc = frame;
    for (int unsigned k = 1; k <= MAX_W; k++) begin
      p = poly >> (k - 1);
      if (k <= data_w && p[0]) begin
        acc = acc ^ MAX_W'(c >> (data_w - k));
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/descrambler_stream_multilane_lane.sv
// One lane: line history, lock flag and combinational descramble of the presented frame.
module descrambler_stream_multilane_lane
  import descrambler_pkg::*;
#(
  parameter int unsigned      DATA_W = 30,
  parameter logic [DATA_W-1:0] POLY  = DATA_W'(DEFAULT_POLY),
  parameter logic [DATA_W-1:0] SEED  = DATA_W'(DEFAULT_SEED)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              accept_i,
  input  logic              enable_i,
  input  logic              resync_i,
  input  logic [DATA_W-1:0] frame_i,
  output logic [DATA_W-1:0] data_c,
  output logic              locked_c
);

  logic [DATA_W-1:0] hist_q, hist_d;
  logic              lock_q, lock_d;
  logic [MAX_W-1:0]  taps;

  always_comb begin
    taps     = descramble_taps(MAX_W'(hist_q), MAX_W'(frame_i), MAX_W'(POLY), DATA_W);
    data_c   = enable_i ? DATA_W'(taps) : frame_i;
    locked_c = lock_q;
  end

  // Resync overrides any same-cycle history update.
  always_comb begin
    hist_d = hist_q;
    lock_d = lock_q;
    if (resync_i) begin
      hist_d = SEED;
      lock_d = 1'b0;
    end else if (accept_i && enable_i) begin
      hist_d = frame_i;
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hist_q <= SEED;
      lock_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/descrambler_stream_multilane.sv
// Multi-lane self-synchronising descrambler: shared handshake, output register and frame counter.
module descrambler_stream_multilane
  import descrambler_pkg::*;
#(
  parameter int unsigned       DATA_W = 30,
  parameter int unsigned       LANES  = 1,
  parameter logic [DATA_W-1:0] POLY   = DATA_W'(DEFAULT_POLY),
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEFAULT_SEED),
  parameter int unsigned       CNT_W  = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*DATA_W-1:0] in_data_i,
  input  logic [LANES-1:0]        in_enable_i,
  input  logic                    resync_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*DATA_W-1:0] out_data_o,
  output logic [LANES-1:0]        out_locked_o,
  output logic [CNT_W-1:0]        frame_count_o
);

  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]        out_locked_q, out_locked_d;
  logic [CNT_W-1:0]        frame_count_q, frame_count_d;
  logic                    accept;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    descrambler_stream_multilane_lane #(
      .DATA_W(DATA_W),
      .POLY  (POLY),
      .SEED  (SEED)
    ) u_lane (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .accept_i(accept),
      .enable_i(in_enable_i[l]),
      .resync_i(resync_i),
      .frame_i (in_data_i[l*DATA_W +: DATA_W]),
      .data_c  (out_data_d[l*DATA_W +: DATA_W]),
      .locked_c(out_locked_d[l])
    );
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    frame_count_d = frame_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      if (frame_count_q != '1) begin
        frame_count_d = frame_count_q + CNT_W'(1);
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_locked_q  <= '0;
      frame_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      frame_count_q <= frame_count_d;
      if (accept) begin
        out_data_q   <= out_data_d;
        out_locked_q <= out_locked_d;
      end
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_locked_o  = out_locked_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_descrambler_stream_multilane.sv
// Directed bench: default single-lane instance plus a 4-lane 16-bit instance with a 2-bit counter.
module tb_descrambler_stream_multilane;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: defaults
  logic        a_in_valid = 1'b0, a_resync = 1'b0, a_out_ready = 1'b1;
  logic [29:0] a_in_data = '0;
  logic [0:0]  a_in_enable = '0;
  logic        a_in_ready, a_out_valid;
  logic [29:0] a_out_data;
  logic [0:0]  a_out_locked;
  logic [15:0] a_count;

  descrambler_stream_multilane u_dut_a (
    .clock_i(clk), .reset_i(reset),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .in_enable_i(a_in_enable), .resync_i(a_resync),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_locked_o(a_out_locked), .frame_count_o(a_count)
  );

  // Instance B: 4 lanes x 16 bits, lags {4,16}
  localparam logic [15:0] B_POLY = 16'h8008;
  localparam logic [15:0] B_SEED = 16'hACE1;
  logic        b_in_valid = 1'b0, b_resync = 1'b0, b_out_ready = 1'b1;
  logic [63:0] b_in_data = '0;
  logic [3:0]  b_in_enable = '0;
  logic        b_in_ready, b_out_valid;
  logic [63:0] b_out_data;
  logic [3:0]  b_out_locked;
  logic [1:0]  b_count;

  descrambler_stream_multilane #(
    .DATA_W(16), .LANES(4), .POLY(B_POLY), .SEED(B_SEED), .CNT_W(2)
  ) u_dut_b (
    .clock_i(clk), .reset_i(reset),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .in_enable_i(b_in_enable), .resync_i(b_resync),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_locked_o(b_out_locked), .frame_count_o(b_count)
  );

  localparam logic [63:0] A_POLY64 = 64'h3000_6000;
  logic [29:0] s_prev;
  logic [15:0] cnt_m;

  // Reference descrambler, bit by bit over the stream c = {frame, hist}
  function automatic logic [63:0] ref_desc(input logic [63:0] hist, input logic [63:0] frame,
                                           input logic [63:0] poly, input int w);
    logic [63:0] r;
    logic b;
    int idx;
    r = '0;
    for (int i = 0; i < w; i++) begin
      b = frame[6'(i)];
      for (int k = 1; k <= w; k++) begin
        if (poly[6'(k-1)]) begin
          idx = w + i - k;
          if (idx >= w) b = b ^ frame[6'(idx-w)];
          else          b = b ^ hist[6'(idx)];
        end
      end
      r[6'(i)] = b;
    end
    return r;
  endfunction

  // Reference multiplicative scrambler: s[n] = d[n] ^ XOR_k s[n-k]
  function automatic logic [63:0] ref_scr(input logic [63:0] prev_s, input logic [63:0] d,
                                          input logic [63:0] poly, input int w);
    logic [63:0] s;
    logic b;
    int idx;
    s = '0;
    for (int i = 0; i < w; i++) begin
      b = d[6'(i)];
      for (int k = 1; k <= w; k++) begin
        if (poly[6'(k-1)]) begin
          idx = w + i - k;
          if (idx >= w) b = b ^ s[6'(idx-w)];
          else          b = b ^ prev_s[6'(idx)];
        end
      end
      s[6'(i)] = b;
    end
    return s;
  endfunction

  task automatic a_drive(input logic v, input logic [29:0] d, input logic en,
                         input logic rs, input logic rdy);
    a_in_valid = v; a_in_data = d; a_in_enable = en; a_resync = rs; a_out_ready = rdy;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_resync = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    a_drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 30'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", a_out_data); end
    n_cmp++; if (a_out_locked !== 1'b0) begin n_err++; $display("FAIL reset_out_locked got %b want 0", a_out_locked); end
    n_cmp++; if (a_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", a_count); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    n_cmp++; if (b_count !== 2'd0 || b_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_b got cnt %0d valid %b want 0 0", b_count, b_out_valid); end
    cnt_m = 16'd0;
  endtask

  task automatic test_zero_frames();
    a_drive(1'b1, 30'h0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL zero1_valid got %b want 1", a_out_valid); end
    n_cmp++; if (a_out_data !== 30'h3FFF_8000) begin n_err++; $display("FAIL zero1_data got %h want 3fff8000", a_out_data); end
    n_cmp++; if (a_out_locked !== 1'b0) begin n_err++; $display("FAIL zero1_locked got %b want 0", a_out_locked); end
    a_drive(1'b1, 30'h0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (a_out_data !== 30'h0) begin n_err++; $display("FAIL zero2_data got %h want 0", a_out_data); end
    n_cmp++; if (a_out_locked !== 1'b1) begin n_err++; $display("FAIL zero2_locked got %b want 1", a_out_locked); end
    n_cmp++; if (a_count !== 16'd2) begin n_err++; $display("FAIL zero2_count got %0d want 2", a_count); end
    a_drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL zero_drain_valid got %b want 0", a_out_valid); end
    cnt_m = 16'd2;
  endtask

  task automatic test_scrambler_stream();
    logic [29:0] d, s;
    a_drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    s_prev = '0;
    for (int n = 0; n < 8; n++) begin
      d = 30'($urandom);
      s = 30'(ref_scr(64'(s_prev), 64'(d), A_POLY64, 30));
      s_prev = s;
      a_drive(1'b1, s, 1'b1, 1'b0, 1'b1);
      cnt_m++;
      if (n > 0) begin
        n_cmp++; if (a_out_data !== d) begin n_err++; $display("FAIL scr_data[%0d] got %h want %h", n, a_out_data, d); end
      end
      n_cmp++; if (a_out_locked !== 1'(n > 0)) begin n_err++; $display("FAIL scr_locked[%0d] got %b want %b", n, a_out_locked, n > 0); end
    end
    n_cmp++; if (a_count !== cnt_m) begin n_err++; $display("FAIL scr_count got %0d want %0d", a_count, cnt_m); end
  endtask

  task automatic test_bypass();
    logic [29:0] d, s;
    a_drive(1'b1, 30'h0123_4567, 1'b0, 1'b0, 1'b1);
    cnt_m++;
    n_cmp++; if (a_out_data !== 30'h0123_4567) begin n_err++; $display("FAIL bypass_data got %h want 01234567", a_out_data); end
    n_cmp++; if (a_out_locked !== 1'b1) begin n_err++; $display("FAIL bypass_locked got %b want 1", a_out_locked); end
    d = 30'($urandom);
    s = 30'(ref_scr(64'(s_prev), 64'(d), A_POLY64, 30));
    s_prev = s;
    a_drive(1'b1, s, 1'b1, 1'b0, 1'b1);
    cnt_m++;
    n_cmp++; if (a_out_data !== d) begin n_err++; $display("FAIL bypass_next_data got %h want %h", a_out_data, d); end
  endtask

  task automatic test_backpressure();
    logic [29:0] d1, s1, d2, s2, d3, s3;
    d1 = 30'($urandom); s1 = 30'(ref_scr(64'(s_prev), 64'(d1), A_POLY64, 30));
    d2 = 30'($urandom); s2 = 30'(ref_scr(64'(s1), 64'(d2), A_POLY64, 30));
    d3 = 30'($urandom); s3 = 30'(ref_scr(64'(s2), 64'(d3), A_POLY64, 30));
    s_prev = s3;
    a_drive(1'b1, s1, 1'b1, 1'b0, 1'b1);
    cnt_m++;
    for (int n = 0; n < 3; n++) begin
      a_drive(1'b1, s2, 1'b1, 1'b0, 1'b0);
      a_out_ready = 1'b0;
      n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", n, a_in_ready); end
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== d1) begin n_err++; $display("FAIL bp_hold[%0d] got v%b %h want v1 %h", n, a_out_valid, a_out_data, d1); end
      n_cmp++; if (a_count !== cnt_m) begin n_err++; $display("FAIL bp_count[%0d] got %0d want %0d", n, a_count, cnt_m); end
    end
    a_drive(1'b1, s2, 1'b1, 1'b0, 1'b1);
    cnt_m++;
    n_cmp++; if (a_out_data !== d2) begin n_err++; $display("FAIL bp_resume1 got %h want %h", a_out_data, d2); end
    a_drive(1'b1, s3, 1'b1, 1'b0, 1'b1);
    cnt_m++;
    n_cmp++; if (a_out_data !== d3 || a_count !== cnt_m) begin n_err++; $display("FAIL bp_resume2 got %h cnt %0d want %h cnt %0d", a_out_data, a_count, d3, cnt_m); end
    a_drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", a_out_valid); end
  endtask

  task automatic test_resync();
    logic [29:0] d, s;
    d = 30'($urandom);
    s = 30'(ref_scr(64'(s_prev), 64'(d), A_POLY64, 30));
    a_drive(1'b1, s, 1'b1, 1'b1, 1'b1);
    cnt_m++;
    n_cmp++; if (a_out_data !== d) begin n_err++; $display("FAIL resync_same_data got %h want %h", a_out_data, d); end
    n_cmp++; if (a_out_locked !== 1'b1) begin n_err++; $display("FAIL resync_same_locked got %b want 1", a_out_locked); end
    a_drive(1'b1, 30'h0, 1'b1, 1'b0, 1'b1);
    cnt_m++;
    n_cmp++; if (a_out_data !== 30'h3FFF_8000) begin n_err++; $display("FAIL resync_next_data got %h want 3fff8000", a_out_data); end
    n_cmp++; if (a_out_locked !== 1'b0) begin n_err++; $display("FAIL resync_next_locked got %b want 0", a_out_locked); end
    n_cmp++; if (a_count !== cnt_m) begin n_err++; $display("FAIL resync_count got %0d want %0d", a_count, cnt_m); end
    a_drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_lanes();
    logic [15:0] hist_m [4];
    logic [3:0]  lock_m, exp_lock;
    logic [63:0] vec, exp_vec;
    logic [15:0] frame, lane_out;
    logic [1:0]  exp_cnt;
    for (int l = 0; l < 4; l++) hist_m[l] = B_SEED;
    lock_m = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      vec = {$urandom, $urandom};
      exp_vec = '0;
      exp_lock = lock_m;
      for (int l = 0; l < 4; l++) begin
        frame = 16'(vec >> (l * 16));
        if (l % 2 == 1) begin
          lane_out = 16'(ref_desc(64'(hist_m[l]), 64'(frame), 64'(B_POLY), 16));
          hist_m[l] = frame;
          lock_m = lock_m | (4'b0001 << l);
        end else begin
          lane_out = frame;
        end
        exp_vec = exp_vec | (64'(lane_out) << (l * 16));
      end
      exp_cnt = (n >= 2) ? 2'd3 : 2'(n + 1);
      b_in_valid = 1'b1; b_in_data = vec; b_in_enable = 4'b1010;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      n_cmp++; if (b_out_data !== exp_vec) begin n_err++; $display("FAIL lanes_data[%0d] got %h want %h", n, b_out_data, exp_vec); end
      n_cmp++; if (b_out_locked !== exp_lock) begin n_err++; $display("FAIL lanes_locked[%0d] got %b want %b", n, b_out_locked, exp_lock); end
      n_cmp++; if (b_count !== exp_cnt) begin n_err++; $display("FAIL lanes_count[%0d] got %0d want %0d", n, b_count, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_frames();
    test_scrambler_stream();
    test_bypass();
    test_backpressure();
    test_resync();
    test_lanes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/descrambler_stream_multilane.md
# descrambler_stream_multilane

Parametrised, multi-lane, self-synchronising (multiplicative) descrambler with a valid/ready stream interface, per-lane bypass, a lock indication and a resync control. It sits on the receive path directly after frame alignment, and each lane delivers descrambled frames to downstream decoding. It generalises the fixed 30-bit descrambler to configurable width, polynomial, seed and lane count. It adds backpressure, lock tracking and frame counting.

## Interface
- DATA_W, 30: frame width per lane, in bits; must be ≥ 2.
- LANES, 1: number of independent lanes sharing one handshake.
- POLY, 30'h3000_6000: tap mask; bit k-1 set means lag k, with 1 ≤ k ≤ DATA_W. The default gives lags {14,15,29,30}.
- SEED, 30'h2AAA_AAAA: per-lane history value loaded at reset and on resync.
- CNT_W, 16: width of the accepted-frame counter.

Ports:
- clock  in  1  Single clock; all logic is on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- in_valid  in  1  Input frame valid.
- in_ready  out  1  Input can be accepted.
- in_data  in  LANES*DATA_W  Scrambled frames; lane L occupies bits [L*DATA_W +: DATA_W].
- in_enable  in  LANES  Per lane, sampled with the frame: 1 = descramble, 0 = bypass.
- resync  in  1  Reload every lane's history with SEED and clear lock.
- out_valid  out  1  Output frame valid.
- out_ready  in  1  Downstream accepts the output.
- out_data  out  LANES*DATA_W  Descrambled (or bypassed) frames.
- out_locked  out  LANES  The frame was descrambled with real line history, not the seed.
- frame_count  out  CNT_W  Accepted input frames; saturates at all-ones.

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is a single output register with no skid buffer.
- Per lane, form the bit stream c = {in_frame, history}, where history is the previous accepted enabled frame.
  - c[j] = history[j] for j < DATA_W.
  - c[j] = in_frame[j-DATA_W] otherwise.
- Descrambled bit i: out[i] = c[DATA_W+i] XOR (XOR over all set lags k of c[DATA_W+i-k]).
- Enable = 1 on accept:
  - out = descrambled value; history ← in_frame.
  - out_locked ← lane lock flag before update; lock flag ← 1.
- Enable = 0 on accept:
  - out = in_frame unchanged; history and lock flag hold.
  - out_locked ← current lock flag.
- resync asserted: every lane's history ← SEED and lock flag ← 0 at the clock edge.
  - If a frame is accepted in the same cycle, it is processed with the pre-resync history and lock flag. Resync then wins for the state update.
- frame_count increments on each accept and holds at 2^CNT_W − 1. resync does not clear it.
- Output register: loaded on accept. out_valid clears when out_valid && out_ready and no new accept occurs.
- A frame present without accept leaves all state unchanged.

## Timing
- Latency: 1 cycle from accept to out_valid/out_data.
- Throughput: 1 frame per cycle while out_ready stays high.
- Reset values:
  - out_valid = 0, out_data = 0, out_locked = 0.
  - frame_count = 0, lock flags = 0, history = SEED.
  - in_ready = 1 in the first cycle after reset deasserts.
- While out_valid && !out_ready: out_data and out_locked are held stable and in_ready = 0.
- Reset asserted mid-stream: an in-flight output is discarded, with no partial update.
- The history is fully flushed after one enabled frame because every lag is ≤ DATA_W, so lock is set after exactly one accepted enabled frame.

## Structure
- Shared package descrambler_pkg:
  - default POLY and SEED constants;
  - a tap-evaluation function (history, frame, POLY) → DATA_W-bit result.
- Sub-module descrambler_lane: holds one lane's history register, lock flag and combinational descramble. It is generated LANES times.
- The top level owns the handshake, output register and frame counter.

## Test plan
- Defaults, reset, then accept in_data = 0 with enable = 1 → out_data = 30'h3FFF_8000, out_locked = 0. A second zero frame → out_data = 0, out_locked = 1, frame_count = 2.
- Random data through a reference multiplicative scrambler seeded 30'h0 → the descrambler output matches the original from the second frame on, with out_locked = 1 from the second frame on.
- enable = 0 with in_data = 30'h0123_4567 → out_data = 30'h0123_4567 and history is unchanged; the next enabled frame decodes as if the bypass frame never occurred.
- Hold out_ready = 0 for 3 cycles with out_valid = 1 → in_ready = 0, out_data stable, frame_count unchanged; releasing out_ready resumes 1 frame per cycle with no loss.
- resync in the same cycle as an accepted frame → that frame uses the old history and its out_locked = 1; the following frame has out_locked = 0 and decodes against SEED.
- LANES = 4, DATA_W = 16, CNT_W = 2 with per-lane enable patterns 1010 → lanes are independent and correct; frame_count saturates at 3.
